// File: rtl/t_state_sequencer_if.sv
// rtl/t_state_sequencer_if.sv - control and T-state bundle between sequencer and control decoder
interface t_state_sequencer_if #(
   parameter int T_STATES = 6,
   parameter int IDX_W    = 3
);
   logic                enable;
   logic                extended_fetch;
   logic                end_cycle;
   logic                halt;
   logic [T_STATES-1:0] t_state;
   logic [IDX_W-1:0]    t_index;
   logic                fetch_phase;
   logic                ext_phase;
   logic                cycle_start;
   logic                halted;

   modport master (
      output enable, extended_fetch, end_cycle, halt,
      input  t_state, t_index, fetch_phase, ext_phase, cycle_start, halted
   );

   modport slave (
      input  enable, extended_fetch, end_cycle, halt,
      output t_state, t_index, fetch_phase, ext_phase, cycle_start, halted
   );
endinterface

// File: rtl/t_state_sequencer.sv
// rtl/t_state_sequencer.sv - parametrised T-state generator with extended fetch, early end and halt
module t_state_sequencer #(
   parameter int T_STATES     = 6,
   parameter int FETCH_STATES = 3,
   parameter int EXT_STATES   = 2,
   parameter int IDX_W        = 3
) (
   input  logic               clk,
   input  logic               clear,
   t_state_sequencer_if.slave bus
);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(T_STATES - 1);
   localparam logic [IDX_W-1:0] FETCH_IDX  = IDX_W'(FETCH_STATES);
   localparam logic [IDX_W-1:0] FETCH_LAST = IDX_W'(FETCH_STATES - 1);
   localparam logic [3:0]       EXT_LAST   = 4'(EXT_STATES - 1);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_EXT  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] t_index, t_index_nx;
   logic [3:0]       ext_cnt, ext_cnt_nx;

   always_ff @(posedge clk) begin
      if (clear) begin
         state   <= S_RUN;
         t_index <= '0;
         ext_cnt <= '0;
      end else begin
         state   <= state_nx;
         t_index <= t_index_nx;
         ext_cnt <= ext_cnt_nx;
      end
   end

   // Priority: halt > enable low > end_cycle > extended_fetch > advance
   always_comb begin
      state_nx   = state;
      t_index_nx = t_index;
      ext_cnt_nx = ext_cnt;
      case (state)
         S_RUN: begin
            if (bus.halt) begin
               state_nx   = S_HALT;
               t_index_nx = '0;
               ext_cnt_nx = '0;
            end else if (bus.enable) begin
               if (bus.end_cycle && (t_index >= FETCH_IDX)) begin
                  t_index_nx = '0;
               end else if (bus.extended_fetch && (t_index == FETCH_LAST)) begin
                  state_nx   = S_EXT;
                  ext_cnt_nx = '0;
               end else if (t_index == LAST_IDX) begin
                  t_index_nx = '0;
               end else begin
                  t_index_nx = t_index + IDX_W'(1);
               end
            end
         end
         S_EXT: begin
            if (bus.halt) begin
               state_nx   = S_HALT;
               t_index_nx = '0;
               ext_cnt_nx = '0;
            end else if (bus.enable) begin
               if (ext_cnt == EXT_LAST) begin
                  state_nx   = S_RUN;
                  t_index_nx = FETCH_IDX;
                  ext_cnt_nx = '0;
               end else begin
                  ext_cnt_nx = ext_cnt + 4'd1;
               end
            end
         end
         S_HALT: begin
            t_index_nx = '0;
            ext_cnt_nx = '0;
         end
         default: begin
            state_nx   = S_RUN;
            t_index_nx = '0;
            ext_cnt_nx = '0;
         end
      endcase
   end

   // Outputs depend on registered state only, never on the inputs
   always_comb begin
      bus.t_state     = '0;
      bus.t_index     = t_index;
      bus.fetch_phase = 1'b0;
      bus.ext_phase   = 1'b0;
      bus.cycle_start = 1'b0;
      bus.halted      = 1'b0;
      if (state == S_HALT) begin
         bus.halted  = 1'b1;
         bus.t_index = '0;
      end else begin
         bus.t_state     = {{(T_STATES-1){1'b0}}, 1'b1} << t_index;
         bus.fetch_phase = (t_index < FETCH_IDX);
         bus.ext_phase   = (state == S_EXT);
         bus.cycle_start = (t_index == '0);
      end
   end
endmodule

// File: tb/tb_t_state_sequencer.sv
// tb/tb_t_state_sequencer.sv - directed self-checking bench for t_state_sequencer
module tb_t_state_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clear_a, clear_b;
   int   vectors = 0;
   int   miscompares = 0;

   t_state_sequencer_if #(.T_STATES(6), .IDX_W(3)) bus_a ();
   t_state_sequencer_if #(.T_STATES(8), .IDX_W(3)) bus_b ();

   t_state_sequencer #(.T_STATES(6), .FETCH_STATES(3), .EXT_STATES(2), .IDX_W(3)) dut_a (
      .clk   (clk),
      .clear (clear_a),
      .bus   (bus_a.slave)
   );

   t_state_sequencer #(.T_STATES(8), .FETCH_STATES(4), .EXT_STATES(3), .IDX_W(3)) dut_b (
      .clk   (clk),
      .clear (clear_b),
      .bus   (bus_b.slave)
   );

   logic [12:0] obs_a;
   logic [14:0] obs_b;
   assign obs_a = {bus_a.t_index, bus_a.t_state, bus_a.fetch_phase, bus_a.ext_phase,
                   bus_a.cycle_start, bus_a.halted};
   assign obs_b = {bus_b.t_index, bus_b.t_state, bus_b.fetch_phase, bus_b.ext_phase,
                   bus_b.cycle_start, bus_b.halted};

   // Expected {t_index, t_state, fetch_phase, ext_phase, cycle_start, halted}
   function automatic logic [12:0] exp_a(int idx, bit ext, bit hlt);
      logic [5:0] ts;
      ts = hlt ? 6'd0 : 6'(1 << idx);
      return {(hlt ? 3'd0 : 3'(idx)), ts, 1'(!hlt && idx < 3), ext, 1'(!hlt && idx == 0), hlt};
   endfunction

   function automatic logic [14:0] exp_b(int idx, bit ext, bit hlt);
      logic [7:0] ts;
      ts = hlt ? 8'd0 : 8'(1 << idx);
      return {(hlt ? 3'd0 : 3'(idx)), ts, 1'(!hlt && idx < 4), ext, 1'(!hlt && idx == 0), hlt};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      clear_a = 1'b1;
      bus_a.enable = 1'b0; bus_a.halt = 1'b1;
      bus_a.extended_fetch = 1'b1; bus_a.end_cycle = 1'b1;
      tick();
      vectors++;
      if (obs_a !== exp_a(0, 0, 0)) begin
         miscompares++;
         $display("FAIL reset: got %h want %h", obs_a, exp_a(0, 0, 0));
      end
      bus_a.halt = 1'b0; bus_a.extended_fetch = 1'b0; bus_a.end_cycle = 1'b0;
      clear_a = 1'b0;
   endtask

   task automatic test_count();
      bus_a.enable = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         vectors++;
         if (obs_a !== exp_a((k + 1) % 6, 0, 0)) begin
            miscompares++;
            $display("FAIL count[%0d]: got %h want %h", k, obs_a, exp_a((k + 1) % 6, 0, 0));
         end
      end
   endtask

   task automatic test_end_cycle();
      tick(); tick(); tick();
      vectors++;
      if (obs_a !== exp_a(3, 0, 0)) begin
         miscompares++;
         $display("FAIL end_pre: got %h want %h", obs_a, exp_a(3, 0, 0));
      end
      bus_a.end_cycle = 1'b1; tick();
      vectors++;
      if (obs_a !== exp_a(0, 0, 0)) begin
         miscompares++;
         $display("FAIL end_at_3: got %h want %h", obs_a, exp_a(0, 0, 0));
      end
      bus_a.end_cycle = 1'b0; tick();
      bus_a.end_cycle = 1'b1; tick();
      vectors++;
      if (obs_a !== exp_a(2, 0, 0)) begin
         miscompares++;
         $display("FAIL end_in_fetch: got %h want %h", obs_a, exp_a(2, 0, 0));
      end
      bus_a.end_cycle = 1'b0; tick(); tick(); tick();
      bus_a.end_cycle = 1'b1; tick();
      vectors++;
      if (obs_a !== exp_a(0, 0, 0)) begin
         miscompares++;
         $display("FAIL end_at_last: got %h want %h", obs_a, exp_a(0, 0, 0));
      end
      bus_a.end_cycle = 1'b0;
   endtask

   task automatic test_ext_fetch();
      tick();
      bus_a.extended_fetch = 1'b1; tick();
      vectors++;
      if (obs_a !== exp_a(2, 0, 0)) begin
         miscompares++;
         $display("FAIL ext_ignored: got %h want %h", obs_a, exp_a(2, 0, 0));
      end
      tick();
      vectors++;
      if (obs_a !== exp_a(2, 1, 0)) begin
         miscompares++;
         $display("FAIL ext_wait0: got %h want %h", obs_a, exp_a(2, 1, 0));
      end
      bus_a.end_cycle = 1'b1; tick();
      vectors++;
      if (obs_a !== exp_a(2, 1, 0)) begin
         miscompares++;
         $display("FAIL ext_wait1: got %h want %h", obs_a, exp_a(2, 1, 0));
      end
      tick();
      vectors++;
      if (obs_a !== exp_a(3, 0, 0)) begin
         miscompares++;
         $display("FAIL ext_exit: got %h want %h", obs_a, exp_a(3, 0, 0));
      end
      bus_a.extended_fetch = 1'b0; bus_a.end_cycle = 1'b0;
   endtask

   task automatic test_enable_freeze();
      bus_a.enable = 1'b0; bus_a.end_cycle = 1'b1; bus_a.extended_fetch = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (obs_a !== exp_a(3, 0, 0)) begin
            miscompares++;
            $display("FAIL freeze_run[%0d]: got %h want %h", k, obs_a, exp_a(3, 0, 0));
         end
      end
      bus_a.enable = 1'b1; bus_a.end_cycle = 1'b0; bus_a.extended_fetch = 1'b0;
      tick();
      vectors++;
      if (obs_a !== exp_a(4, 0, 0)) begin
         miscompares++;
         $display("FAIL resume_run: got %h want %h", obs_a, exp_a(4, 0, 0));
      end
      tick(); tick(); tick(); tick();
      bus_a.extended_fetch = 1'b1; tick();
      bus_a.extended_fetch = 1'b0; bus_a.enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (obs_a !== exp_a(2, 1, 0)) begin
            miscompares++;
            $display("FAIL freeze_ext[%0d]: got %h want %h", k, obs_a, exp_a(2, 1, 0));
         end
      end
      bus_a.enable = 1'b1; tick();
      vectors++;
      if (obs_a !== exp_a(2, 1, 0)) begin
         miscompares++;
         $display("FAIL resume_ext: got %h want %h", obs_a, exp_a(2, 1, 0));
      end
      tick();
      vectors++;
      if (obs_a !== exp_a(3, 0, 0)) begin
         miscompares++;
         $display("FAIL resume_exit: got %h want %h", obs_a, exp_a(3, 0, 0));
      end
      tick();
   endtask

   task automatic test_halt();
      bus_a.halt = 1'b1; bus_a.enable = 1'b0; tick();
      vectors++;
      if (obs_a !== exp_a(0, 0, 1)) begin
         miscompares++;
         $display("FAIL halt_entry: got %h want %h", obs_a, exp_a(0, 0, 1));
      end
      bus_a.halt = 1'b0; bus_a.enable = 1'b1;
      bus_a.end_cycle = 1'b1; bus_a.extended_fetch = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         vectors++;
         if (obs_a !== exp_a(0, 0, 1)) begin
            miscompares++;
            $display("FAIL halt_hold[%0d]: got %h want %h", k, obs_a, exp_a(0, 0, 1));
         end
      end
      bus_a.end_cycle = 1'b0; bus_a.extended_fetch = 1'b0;
      clear_a = 1'b1; tick(); clear_a = 1'b0;
      vectors++;
      if (obs_a !== exp_a(0, 0, 0)) begin
         miscompares++;
         $display("FAIL halt_clear: got %h want %h", obs_a, exp_a(0, 0, 0));
      end
      tick(); tick();
      bus_a.extended_fetch = 1'b1; tick();
      bus_a.extended_fetch = 1'b0; bus_a.halt = 1'b1; tick();
      vectors++;
      if (obs_a !== exp_a(0, 0, 1)) begin
         miscompares++;
         $display("FAIL halt_from_ext: got %h want %h", obs_a, exp_a(0, 0, 1));
      end
      bus_a.halt = 1'b0;
   endtask

   task automatic test_config_b();
      int idx_seq [11] = '{1, 2, 3, 3, 3, 3, 4, 5, 6, 7, 0};
      bit ext_seq [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
      bus_b.enable = 1'b1; bus_b.halt = 1'b0;
      bus_b.end_cycle = 1'b0; bus_b.extended_fetch = 1'b1;
      clear_b = 1'b1; tick(); clear_b = 1'b0;
      vectors++;
      if (obs_b !== exp_b(0, 0, 0)) begin
         miscompares++;
         $display("FAIL b_reset: got %h want %h", obs_b, exp_b(0, 0, 0));
      end
      for (int k = 0; k < 11; k++) begin
         tick();
         vectors++;
         if (obs_b !== exp_b(idx_seq[k], ext_seq[k], 0)) begin
            miscompares++;
            $display("FAIL b_seq[%0d]: got %h want %h", k, obs_b, exp_b(idx_seq[k], ext_seq[k], 0));
         end
      end
      tick(); tick(); tick(); tick(); tick();
      vectors++;
      if (obs_b !== exp_b(3, 1, 0)) begin
         miscompares++;
         $display("FAIL b_mid_ext: got %h want %h", obs_b, exp_b(3, 1, 0));
      end
      clear_b = 1'b1; tick(); clear_b = 1'b0;
      vectors++;
      if (obs_b !== exp_b(0, 0, 0)) begin
         miscompares++;
         $display("FAIL b_clear_ext: got %h want %h", obs_b, exp_b(0, 0, 0));
      end
   endtask

   initial begin
      clear_b = 1'b1;
      bus_b.enable = 1'b0; bus_b.halt = 1'b0;
      bus_b.end_cycle = 1'b0; bus_b.extended_fetch = 1'b0;
      test_reset();
      test_count();
      test_end_cycle();
      test_ext_fetch();
      test_enable_freeze();
      test_halt();
      test_config_b();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
